sram_wishbone_port: RTL and testbench



---
 rtl/sram_wishbone_port_pkg.sv | 14 +
 rtl/sram_wishbone_port.sv | 90 +++++++++
 tb/tb_sram_wishbone_port.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sram_wishbone_port_pkg.sv
// Shared constants for the Wishbone-to-SRAM port: FSM state encoding and word geometry
// common to the SRAM macro wrapper.
package sram_wishbone_port_pkg;

    localparam int unsigned WB_ADDRESS_SIZE_DEFAULT = 24;
    localparam int unsigned BYTE_COUNT_DEFAULT      = 4;
    localparam int unsigned WORD_SIZE               = 8 * BYTE_COUNT_DEFAULT;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StReadWait = 2'd1;
    localparam logic [1:0] StAck      = 2'd2;
    localparam logic [1:0] StError    = 2'd3;

endpackage

// File: rtl/sram_wishbone_port.sv
// Wishbone classic slave in front of a single-port synchronous SRAM; absorbs the one-cycle
// read latency and returns an error for addresses beyond the populated range.
module sram_wishbone_port
    import sram_wishbone_port_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE    = 9,
    parameter int unsigned BYTE_COUNT      = BYTE_COUNT_DEFAULT,
    parameter int unsigned WB_ADDRESS_SIZE = WB_ADDRESS_SIZE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [BYTE_COUNT-1:0]      wb_sel_i,
    input  logic [WB_ADDRESS_SIZE-1:0] wb_adr_i,
    input  logic [WORD_SIZE-1:0]       wb_data_i,
    output logic                       wb_ack_o,
    output logic                       wb_error_o,
    output logic [WORD_SIZE-1:0]       wb_data_o,

    output logic                       sramSelect,
    output logic                       sramWriteEnable,
    output logic [BYTE_COUNT-1:0]      sramWriteMask,
    output logic [ADDRESS_SIZE-1:0]    sramAddress,
    output logic [WORD_SIZE-1:0]       sramDataWrite,
    input  logic [WORD_SIZE-1:0]       sramDataRead
);

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] data_q, data_d;

    logic request;
    logic in_range;
    logic idle;
    logic unused_adr_bits;

    // Byte offset within the word carries no meaning for word-organised SRAM.
    assign unused_adr_bits = ^wb_adr_i[1:0];

    assign idle     = (state_q == StIdle);
    assign request  = wb_cyc_i & wb_stb_i;
    assign in_range = (wb_adr_i[WB_ADDRESS_SIZE-1:ADDRESS_SIZE+2] == '0);

    assign sramAddress     = wb_adr_i[ADDRESS_SIZE+1:2];
    assign sramWriteMask   = wb_sel_i;
    assign sramDataWrite   = wb_data_i;
    assign sramSelect      = idle & request & in_range & (~wb_we_i | (wb_sel_i != '0));
    assign sramWriteEnable = idle & request & in_range & wb_we_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (request) begin
                    if (!in_range) begin
                        state_d = StError;
                    end else if (wb_we_i) begin
                        state_d = StAck;
                    end else begin
                        state_d = StReadWait;
                    end
                end
            end
            StReadWait: begin
                data_d  = sramDataRead;
                // Master gave up while the SRAM was still reading: drop without ack.
                state_d = wb_cyc_i ? StAck : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign wb_ack_o   = (state_q == StAck) & wb_cyc_i;
    assign wb_error_o = (state_q == StError) & wb_cyc_i;
    assign wb_data_o  = data_q;

endmodule

// File: tb/tb_sram_wishbone_port.sv
// Directed bench for sram_wishbone_port with a behavioural SRAM and a read-data scoreboard.
module tb_sram_wishbone_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [23:0] wb_adr_i = 24'h0;
    logic [31:0] wb_data_i = 32'h0;
    logic        wb_ack_o;
    logic        wb_error_o;
    logic [31:0] wb_data_o;
    logic        sramSelect;
    logic        sramWriteEnable;
    logic [3:0]  sramWriteMask;
    logic [8:0]  sramAddress;
    logic [31:0] sramDataWrite;
    logic [31:0] sramDataRead;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] sram_mem [512];
    logic [31:0] shadow [512];
    logic [31:0] last_read = 32'h0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    sram_wishbone_port dut (
        .clk             (clk),
        .rst             (rst),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_we_i         (wb_we_i),
        .wb_sel_i        (wb_sel_i),
        .wb_adr_i        (wb_adr_i),
        .wb_data_i       (wb_data_i),
        .wb_ack_o        (wb_ack_o),
        .wb_error_o      (wb_error_o),
        .wb_data_o       (wb_data_o),
        .sramSelect      (sramSelect),
        .sramWriteEnable (sramWriteEnable),
        .sramWriteMask   (sramWriteMask),
        .sramAddress     (sramAddress),
        .sramDataWrite   (sramDataWrite),
        .sramDataRead    (sramDataRead)
    );

    // Synchronous single-port SRAM with byte mask and one-cycle read latency.
    always_ff @(posedge clk) begin
        if (sramSelect) begin
            if (sramWriteEnable) begin
                for (int b = 0; b < 4; b++) begin
                    if (sramWriteMask[b]) sram_mem[sramAddress][8*b +: 8] <= sramDataWrite[8*b +: 8];
                end
            end else begin
                sramDataRead <= sram_mem[sramAddress];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag);
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            check(tag, wb_data_o, sb_q.pop_front());
        end
    endtask

    task automatic wb_write(input logic [23:0] adr, input logic [31:0] data, input logic [3:0] sel);
        logic [8:0] w;
        w = adr[10:2];
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr; wb_data_i = data; wb_sel_i = sel;
        #1;
        check("wr_select", {31'h0, sramSelect}, {31'h0, sel != 4'h0});
        check("wr_enable", {31'h0, sramWriteEnable}, 32'h1);
        check("wr_address", {23'h0, sramAddress}, {23'h0, w});
        check("wr_mask", {28'h0, sramWriteMask}, {28'h0, sel});
        check("wr_no_early_ack", {31'h0, wb_ack_o}, 32'h0);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) shadow[w][8*b +: 8] = data[8*b +: 8];
        end
        @(posedge clk); #1;
        check("wr_ack", {31'h0, wb_ack_o}, 32'h1);
        check("wr_no_error", {31'h0, wb_error_o}, 32'h0);
        check("wr_strobes_off", {30'h0, sramSelect, sramWriteEnable}, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [23:0] adr);
        logic in_range;
        in_range = (adr[23:11] == 13'h0);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr; wb_sel_i = 4'hF;
        if (in_range) begin
            last_read = shadow[adr[10:2]];
        end
        sb_q.push_back(last_read);
        #1;
        check("rd_select", {31'h0, sramSelect}, {31'h0, in_range});
        check("rd_we_low", {31'h0, sramWriteEnable}, 32'h0);
        @(posedge clk); #1;
        if (!in_range) begin
            check("err_flag", {31'h0, wb_error_o}, 32'h1);
            check("err_no_ack", {31'h0, wb_ack_o}, 32'h0);
            sb_pop_check("err_data_held");
        end else begin
            check("rd_wait_no_ack", {31'h0, wb_ack_o}, 32'h0);
            wb_stb_i = 1'b0;
            @(posedge clk); #1;
            check("rd_ack", {31'h0, wb_ack_o}, 32'h1);
            check("rd_no_error", {31'h0, wb_error_o}, 32'h0);
            sb_pop_check("rd_data");
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_error", {31'h0, wb_error_o}, 32'h0);
        check("rst_data", wb_data_o, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        wb_write(24'h000010, 32'hDEADBEEF, 4'hF);
        wb_read(24'h000010);
        wb_write(24'h000010, 32'h000000AA, 4'h1);
        wb_read(24'h000010);
        wb_read(24'h000013);

        wb_write(24'h000004, 32'h12345678, 4'hF);
        wb_write(24'h000004, 32'hFFFFFFFF, 4'h0);
        shadow[1] = 32'h12345678;
        wb_read(24'h000004);

        wb_read(24'h000800);

        // Abort a read while the SRAM is still returning data.
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 24'h000010;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        last_read = shadow[4];
        @(posedge clk); #1;
        check("abort_no_ack", {31'h0, wb_ack_o}, 32'h0);
        check("abort_no_error", {31'h0, wb_error_o}, 32'h0);
        wb_write(24'h000008, 32'hCAFEF00D, 4'hF);
        wb_read(24'h000008);

        // Asynchronous reset in the middle of READ_WAIT.
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 24'h000010;
        @(posedge clk); #1;
        wb_stb_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("arst_error", {31'h0, wb_error_o}, 32'h0);
        check("arst_data", wb_data_o, 32'h0);
        #1 rst = 1'b0;
        last_read = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_late_ack", {31'h0, wb_ack_o}, 32'h0);
        end
        wb_cyc_i = 1'b0;
        wb_read(24'h000008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
